// File: rtl/axi4lite_reg4_responder_if.sv
// AXI4-Lite bus bundle for the four-register responder, with master and slave views.
interface axi4lite_reg4_responder_if #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
);
  localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic [2:0]                    S_AXI_AWPROT;
  logic                          S_AXI_AWVALID;
  logic                          S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA;
  logic [STRB_W-1:0]             S_AXI_WSTRB;
  logic                          S_AXI_WVALID;
  logic                          S_AXI_WREADY;
  logic [1:0]                    S_AXI_BRESP;
  logic                          S_AXI_BVALID;
  logic                          S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic [2:0]                    S_AXI_ARPROT;
  logic                          S_AXI_ARVALID;
  logic                          S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA;
  logic [1:0]                    S_AXI_RRESP;
  logic                          S_AXI_RVALID;
  logic                          S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi4lite_reg4_responder.sv
// AXI4-Lite responder with four 32-bit R/W registers, flat register bus and per-register write pulses.
module axi4lite_reg4_responder #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] C_REG_RESET        = 32'h0000_0000
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  axi4lite_reg4_responder_if.slave        s_axi,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] regs_o,
  output logic [3:0]                      wr_pulse_o
);
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW       = DW / 8;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_DATA } r_state_e;

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [SEL_W-1:0]  awsel_q, awsel_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              arready_q, arready_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [3:0]        wr_pulse_q, wr_pulse_d;
  logic [DW-1:0]     regs_q [NUM_REGS];
  logic [DW-1:0]     regs_d [NUM_REGS];

  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_in, araddr_in;
  logic aw_fire, w_fire, ar_fire;
  logic unused_inputs;

  assign awaddr_in = s_axi.S_AXI_AWADDR;
  assign araddr_in = s_axi.S_AXI_ARADDR;
  assign aw_fire   = s_axi.S_AXI_AWVALID & awready_q;
  assign w_fire    = s_axi.S_AXI_WVALID & wready_q;
  assign ar_fire   = s_axi.S_AXI_ARVALID & arready_q;

  // Protection bits and byte-offset address bits carry no meaning here.
  assign unused_inputs = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           awaddr_in[1:0], araddr_in[1:0]};

  // Bus outputs: valids come straight from state flops, responses are always OKAY.
  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = (w_state_q == W_RESP);
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = (r_state_q == R_DATA);
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign wr_pulse_o          = wr_pulse_q;
  assign regs_o              = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

  // Write channel: latch AW and W independently, execute once both are held, then respond.
  always_comb begin
    w_state_d  = w_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awsel_d    = awsel_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    awready_d  = 1'b0;
    wready_d   = 1'b0;
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];

    unique case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awsel_d   = awaddr_in[3:2];
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.S_AXI_WDATA;
          wstrb_d  = s_axi.S_AXI_WSTRB;
        end
        if (aw_held_d && w_held_d) begin
          for (int b = 0; b < SW; b++) begin
            if (wstrb_d[b]) regs_d[awsel_d][8*b +: 8] = wdata_d[8*b +: 8];
          end
          wr_pulse_d[awsel_d] = |wstrb_d;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_RESP;
        end else begin
          awready_d = ~aw_held_d;
          wready_d  = ~w_held_d;
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          w_state_d = W_IDLE;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel: capture the addressed register on AR, hold it until R completes.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    arready_d = 1'b0;

    unique case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          rdata_d   = regs_q[araddr_in[3:2]];
          r_state_d = R_DATA;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (s_axi.S_AXI_RREADY) begin
          r_state_d = R_IDLE;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // State and register flops; reset discards any partially latched transaction.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awsel_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= DW'(C_REG_RESET);
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awsel_q    <= awsel_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      arready_q  <= arready_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end
endmodule

// File: tb/tb_axi4lite_reg4_responder.sv
// Self-checking bench for axi4lite_reg4_responder against an array-based register model.
module tb_axi4lite_reg4_responder;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] regs_o;
  logic [3:0]   wr_pulse;

  axi4lite_reg4_responder_if bus ();

  axi4lite_reg4_responder dut (
    .ACLK       (clk),
    .ARESET     (rst),
    .s_axi      (bus),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] model [4];
  int          pulse_cnt [4];

  // Count wr_pulse_o assertions per register, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) for (int i = 0; i < 4; i++) if (wr_pulse[i]) pulse_cnt[i]++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  function automatic logic [127:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.S_AXI_AWADDR  = '0;
    bus.S_AXI_AWPROT  = '0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = '0;
    bus.S_AXI_WSTRB   = '0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b1;
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARPROT  = '0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b1;
  endtask

  // Drives one write (AW and W together) and collects the B response.
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output bit ok);
    bit aw_done, w_done, aw_now, w_now;
    int cyc;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      aw_now = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_now  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      tick();
      if (aw_now) begin bus.S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_now)  begin bus.S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
      cyc++;
    end
    while (!bus.S_AXI_BVALID && cyc < 50) begin tick(); cyc++; end
    ok   = bus.S_AXI_BVALID && aw_done && w_done;
    resp = bus.S_AXI_BRESP;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    tick();
  endtask

  // Drives one read and collects the R response.
  task automatic do_read(input logic [3:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output bit ok);
    bit ar_done, ar_now;
    int cyc;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    ar_done = 1'b0; cyc = 0;
    while (!ar_done && cyc < 50) begin
      ar_now = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
      tick();
      if (ar_now) begin bus.S_AXI_ARVALID = 1'b0; ar_done = 1'b1; end
      cyc++;
    end
    while (!bus.S_AXI_RVALID && cyc < 50) begin tick(); cyc++; end
    ok   = bus.S_AXI_RVALID && ar_done;
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    bus.S_AXI_ARVALID = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; bit ok;
    bus_idle();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin model[i] = 32'h0; pulse_cnt[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b want 000", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}); end
    n_cmp++; if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}); end
    n_cmp++; if ({bus.S_AXI_RDATA, bus.S_AXI_BRESP, bus.S_AXI_RRESP} !== 36'h0) begin n_fail++; $display("FAIL reset_rdata_resp: got %h want 0", {bus.S_AXI_RDATA, bus.S_AXI_BRESP, bus.S_AXI_RRESP}); end
    n_cmp++; if (regs_o !== model_flat()) begin n_fail++; $display("FAIL reset_regs: got %h want %h", regs_o, model_flat()); end
    n_cmp++; if (wr_pulse !== 4'h0) begin n_fail++; $display("FAIL reset_pulse: got %h want 0", wr_pulse); end
    rst = 1'b0;
    tick();
    n_cmp++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin n_fail++; $display("FAIL post_reset_ready: got %b want 111", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}); end
    for (int i = 0; i < 4; i++) begin
      do_read(4'(4*i), d, r, ok);
      n_cmp++; if (!ok || d !== model[i] || r !== 2'b00) begin n_fail++; $display("FAIL reset_read%0d: got ok=%0d data=%h resp=%b want data=%h resp=00", i, ok, d, r, model[i]); end
    end
  endtask

  task automatic test_seq_write_read();
    logic [31:0] vals [4];
    logic [31:0] d; logic [1:0] r; bit ok;
    vals[0] = 32'h0101FFFF; vals[1] = 32'hABCD0001; vals[2] = 32'hDEAD0011; vals[3] = 32'hBEEF0011;
    for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
    for (int i = 0; i < 4; i++) begin
      do_write(4'(4*i), vals[i], 4'hF, r, ok);
      model[i] = vals[i];
      n_cmp++; if (!ok || r !== 2'b00) begin n_fail++; $display("FAIL seq_bresp%0d: got ok=%0d resp=%b want resp=00", i, ok, r); end
    end
    for (int i = 0; i < 4; i++) begin
      do_read(4'(4*i), d, r, ok);
      n_cmp++; if (!ok || d !== model[i] || r !== 2'b00) begin n_fail++; $display("FAIL seq_read%0d: got data=%h resp=%b want data=%h resp=00", i, d, r, model[i]); end
    end
    n_cmp++; if (regs_o !== 128'hBEEF0011_DEAD0011_ABCD0001_0101FFFF) begin n_fail++; $display("FAIL seq_regs_o: got %h want BEEF0011DEAD0011ABCD00010101FFFF", regs_o); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (pulse_cnt[i] !== 1) begin n_fail++; $display("FAIL seq_pulse%0d: got %0d pulses want 1", i, pulse_cnt[i]); end
    end
  endtask

  task automatic test_channel_order();
    logic [31:0] old2, d; logic [1:0] r; bit ok;
    old2 = model[2];
    bus.S_AXI_WDATA  = 32'h12345678;
    bus.S_AXI_WSTRB  = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    n_cmp++; if ({bus.S_AXI_WREADY, bus.S_AXI_AWREADY, bus.S_AXI_BVALID} !== 3'b010) begin n_fail++; $display("FAIL order_w_latched: got wready/awready/bvalid=%b want 010", {bus.S_AXI_WREADY, bus.S_AXI_AWREADY, bus.S_AXI_BVALID}); end
    tick();
    tick();
    n_cmp++; if (regs_o[95:64] !== old2 || bus.S_AXI_BVALID !== 1'b0) begin n_fail++; $display("FAIL order_no_early_update: got reg2=%h bvalid=%b want %h 0", regs_o[95:64], bus.S_AXI_BVALID, old2); end
    bus.S_AXI_AWADDR  = 4'h8;
    bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    model[2] = 32'h12345678;
    n_cmp++; if (bus.S_AXI_BVALID !== 1'b1 || regs_o[95:64] !== model[2] || wr_pulse !== 4'b0100) begin n_fail++; $display("FAIL order_update: got bvalid=%b reg2=%h pulse=%b want 1 %h 0100", bus.S_AXI_BVALID, regs_o[95:64], wr_pulse, model[2]); end
    tick();
    n_cmp++; if (bus.S_AXI_BVALID !== 1'b0) begin n_fail++; $display("FAIL order_b_done: got bvalid=%b want 0", bus.S_AXI_BVALID); end
    do_read(4'h8, d, r, ok);
    n_cmp++; if (!ok || d !== model[2]) begin n_fail++; $display("FAIL order_read: got %h want %h", d, model[2]); end
  endtask

  task automatic test_strobes();
    logic [31:0] d; logic [1:0] r; bit ok; int pc;
    do_write(4'h4, 32'hFFFFFFFF, 4'b0101, r, ok);
    model[1] = apply_strb(model[1], 32'hFFFFFFFF, 4'b0101);
    do_read(4'h4, d, r, ok);
    n_cmp++; if (!ok || d !== model[1] || d !== 32'hABFF00FF) begin n_fail++; $display("FAIL strb_0101: got %h want ABFF00FF", d); end
    pc = pulse_cnt[1];
    do_write(4'h4, 32'h00000000, 4'b0000, r, ok);
    n_cmp++; if (!ok || r !== 2'b00) begin n_fail++; $display("FAIL strb_zero_bresp: got ok=%0d resp=%b want 00", ok, r); end
    n_cmp++; if (pulse_cnt[1] !== pc) begin n_fail++; $display("FAIL strb_zero_pulse: got %0d pulses want %0d", pulse_cnt[1], pc); end
    do_read(4'h4, d, r, ok);
    n_cmp++; if (!ok || d !== model[1]) begin n_fail++; $display("FAIL strb_zero_read: got %h want %h", d, model[1]); end
  endtask

  task automatic test_backpressure_collision();
    logic [31:0] exp_r, d; logic [1:0] r; bit ok;
    tick();
    n_cmp++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin n_fail++; $display("FAIL coll_idle_ready: got %b want 111", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}); end
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    exp_r = model[0];
    bus.S_AXI_AWADDR = 4'h0; bus.S_AXI_WDATA = 32'hCAFEBABE; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_ARADDR = 4'h0;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    tick();
    model[0] = 32'hCAFEBABE;
    bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_WDATA = $urandom; bus.S_AXI_ARADDR = 4'h4;
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 2'b11 || bus.S_AXI_RDATA !== exp_r || {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b000) begin
        n_fail++; $display("FAIL bp_stall_c%0d: got bv/rv=%b rdata=%h rdy=%b want 11 %h 000", c, {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, bus.S_AXI_RDATA, {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, exp_r);
      end
      tick();
    end
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    tick();
    n_cmp++; if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 2'b00 || regs_o !== model_flat()) begin n_fail++; $display("FAIL bp_release: got bv/rv=%b regs=%h want 00 %h", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, regs_o, model_flat()); end
    do_read(4'h0, d, r, ok);
    n_cmp++; if (!ok || d !== 32'hCAFEBABE) begin n_fail++; $display("FAIL coll_next_read: got %h want CAFEBABE", d); end
  endtask

  task automatic test_random();
    logic [31:0] d, data; logic [3:0] addr, strb; logic [1:0] r; bit ok;
    for (int n = 0; n < 30; n++) begin
      addr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        do_write(addr, data, strb, r, ok);
        model[addr[3:2]] = apply_strb(model[addr[3:2]], data, strb);
        n_cmp++; if (!ok || r !== 2'b00) begin n_fail++; $display("FAIL rand_write%0d: got ok=%0d resp=%b want 00", n, ok, r); end
      end else begin
        do_read(addr, d, r, ok);
        n_cmp++; if (!ok || d !== model[addr[3:2]] || r !== 2'b00) begin n_fail++; $display("FAIL rand_read%0d: addr=%h got %h resp=%b want %h", n, addr, d, r, model[addr[3:2]]); end
      end
    end
    n_cmp++; if (regs_o !== model_flat()) begin n_fail++; $display("FAIL rand_regs_o: got %h want %h", regs_o, model_flat()); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d; logic [1:0] r; bit ok;
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    bus.S_AXI_AWADDR = 4'hC; bus.S_AXI_WDATA = $urandom; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_ARADDR = 4'h8;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    tick();
    n_cmp++; if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 2'b11) begin n_fail++; $display("FAIL mrst_pending: got bv/rv=%b want 11", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}); end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    n_cmp++; if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 2'b00 || regs_o !== model_flat()) begin n_fail++; $display("FAIL mrst_async: got bv/rv=%b regs=%h want 00 0", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, regs_o); end
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++; if ({bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 2'b00) begin n_fail++; $display("FAIL mrst_stale_c%0d: got bv/rv=%b want 00", c, {bus.S_AXI_BVALID, bus.S_AXI_RVALID}); end
    end
    for (int i = 0; i < 4; i++) begin
      do_read(4'(4*i), d, r, ok);
      n_cmp++; if (!ok || d !== model[i] || r !== 2'b00) begin n_fail++; $display("FAIL mrst_read%0d: got %h resp=%b want %h", i, d, r, model[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_seq_write_read();
    test_channel_order();
    test_strobes();
    test_backpressure_collision();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4lite_reg4_responder.md
# axi4lite_reg4_responder

AXI4-Lite responder (slave) exposing four 32-bit read/write registers at word offsets 0x0, 0x4, 0x8 and 0xC. It is the bus-side end of the write/readback exercise performed by the AXI4-Lite master BFM. In the AD7641 serial path it holds the control registers and exposes their contents to the acquisition logic through a flat bus and per-register write strobes. Each channel supports one outstanding transaction, and every response is OKAY.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width (fixed at 32)
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, [1:0] ignored
- C_REG_RESET, 32'h0000_0000, reset value of all four registers

Ports (clock and reset first):
- ACLK  in  1  single clock; all logic is on the rising edge
- ARESET  in  1  asynchronous, active-high reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
- S_AXI_BRESP  out  2  always 2'b00
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  always 2'b00
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake
- regs_o  out  128  {reg3, reg2, reg1, reg0}
- wr_pulse_o  out  4  one-cycle pulse per register on update

## Operation
- Write FSM states:
  - W_IDLE: AWREADY=1 until the address is latched; WREADY=1 until the data and strobe are latched. AW and W may arrive in either order or in the same cycle.
  - Write execution: on the edge where both are held (either latched earlier or handshaking on that edge), update the selected register byte-wise per WSTRB (WSTRB[i] selects bits [8i+7:8i]) and pulse wr_pulse_o[sel] for the following cycle. Then go to W_RESP.
  - W_RESP: BVALID=1, AWREADY=0, WREADY=0. Return to W_IDLE on BVALID&BREADY.
- WSTRB=0: no register change, no wr_pulse_o pulse; BVALID is still issued with OKAY.
- Read FSM states:
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY, register RDATA with the selected register's value at that edge, then go to R_DATA.
  - R_DATA: RVALID=1, ARREADY=0, RDATA held stable. Return to R_IDLE on RVALID&RREADY.
- Read and write channels are independent.
- Read/write collision: if a read is accepted on the same edge that a write updates the same register, RDATA returns the pre-write value.
- The BVALID, RVALID and RDATA outputs are registered and do not depend combinationally on any input.
- Backpressure: BVALID and RVALID stay high indefinitely while BREADY/RREADY are low. No new AW, W or AR transfer is accepted until the pending response completes.

## Timing
- Reset (ARESET=1, asynchronous): registers = C_REG_RESET; wr_pulse_o=0; BVALID=0; RVALID=0; RDATA=0; BRESP=RRESP=0; AWREADY=WREADY=ARREADY=0.
- First cycle after reset deasserts: AWREADY=WREADY=ARREADY=1.
- AW and W in the same cycle (edge N): register updated at N; BVALID=1 and wr_pulse_o=1 during cycle N+1. With BREADY held high, AWREADY returns at N+2. Write throughput is one write per 2 cycles.
- AW at edge N, W at edge N+k: update at N+k; BVALID during cycle N+k+1.
- AR at edge N: RVALID and RDATA valid in cycle N+1. With RREADY high, ARREADY returns at N+2.
- Reset asserted mid-transaction: any latched address/data is discarded, pending BVALID/RVALID drop immediately, and registers revert to C_REG_RESET. No response is ever issued for a transaction cut short by reset.

## Test plan
- Reset/idle: hold ARESET high, then release. Reads of 0x0, 0x4, 0x8, 0xC return 0x00000000 with RRESP=00. Check the reset values of every output listed under Timing.
- Sequential write/readback at 0x0, 0x4, 0x8, 0xC with data 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011, WSTRB=F. Every BRESP and RRESP is 00, each readback matches, regs_o = {BEEF0011, DEAD0011, ABCD0001, 0101FFFF}, and each wr_pulse_o bit pulses exactly once.
- Channel ordering: present W 3 cycles before AW at 0x8 with data 0x12345678. The data is latched early, the update and BVALID follow the AW handshake by 1 cycle, and readback is 0x12345678.
- Byte strobes: with 0x4 = 0xABCD0001, write 0xFFFFFFFF with WSTRB=0101. Readback is 0xABFF00FF. A following write with WSTRB=0 leaves the register unchanged and produces no wr_pulse_o pulse.
- Backpressure and collision:
  - Hold BREADY and RREADY low for 10 cycles. BVALID, RVALID and RDATA stay stable, and AWREADY, WREADY and ARREADY stay low.
  - Issue AR and a write of 0xCAFEBABE to 0x0 on the same edge (0x0 previously 0x0101FFFF). The read returns 0x0101FFFF, and the next read returns 0xCAFEBABE.
- Mid-transaction reset: assert ARESET while BVALID is pending. BVALID drops asynchronously, all registers read back 0x00000000, and no stale B or R response appears afterwards.
